// File: rtl/mod_fsm_pkg.sv
// Shared types and helpers for the mod-N sequence checker.
//   state_t : checker lock state (HUNT, SYNC, LOCKED, LOSS), 2-bit encoding
//   mod_nxt : successor of x in the 0..n-1 sequence (n-1 wraps to 0)
package mod_fsm_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        LOSS   = 2'd3
    } state_t;

    // Next value of a mod-n counter.
    function automatic logic [31:0] mod_nxt(input logic [31:0] x, input int unsigned n);
        return (x == 32'(n - 1)) ? 32'd0 : x + 32'd1;
    endfunction

endpackage

// File: rtl/mod_n_seq_checker_if.sv
// Sample stream and status bundle of the mod-N sequence checker.
// Optional feature macro: SEQ_CHK_CLR_EN adds err_clr (synchronous error-count clear).
//   in_valid  : in_q holds a sample this cycle          (master -> slave)
//   in_q      : observed count value, W bits            (master -> slave)
//   err_clr   : clear err_count (SEQ_CHK_CLR_EN only)   (master -> slave)
//   locked    : checker is LOCKED or LOSS               (slave -> master)
//   err_pulse : one-cycle pulse per in-lock mismatch    (slave -> master)
//   err_count : saturating error count, ERR_W bits      (slave -> master)
//   expected  : value expected at the next valid sample (slave -> master)
interface mod_n_seq_checker_if #(
    parameter int unsigned W     = 3,
    parameter int unsigned ERR_W = 8
) ();

    logic             in_valid;
    logic [W-1:0]     in_q;
`ifdef SEQ_CHK_CLR_EN
    logic             err_clr;
`endif
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [W-1:0]     expected;

`ifdef SEQ_CHK_CLR_EN
    modport master (output in_valid, in_q, err_clr,
                    input  locked, err_pulse, err_count, expected);
    modport slave  (input  in_valid, in_q, err_clr,
                    output locked, err_pulse, err_count, expected);
`else
    modport master (output in_valid, in_q,
                    input  locked, err_pulse, err_count, expected);
    modport slave  (input  in_valid, in_q,
                    output locked, err_pulse, err_count, expected);
`endif

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one unless already at all-ones
//   clr        : synchronous clear to zero
//   count      : registered count, WIDTH bits
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mod_n_seq_checker.sv
// Receive-side checker for a mod-N count stream. Acquires lock after LOCK_CNT
// consecutive correct samples, then flywheels its expected value, pulsing
// err_pulse on each in-lock mismatch and dropping lock after LOSS_CNT
// consecutive misses.
// Optional feature macro: SEQ_CHK_CLR_EN (bus.err_clr clears err_count).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mod_n_seq_checker_if.slave (sample input, status outputs)
module mod_n_seq_checker
    import mod_fsm_pkg::*;
#(
    parameter int unsigned N        = 5,
    parameter int unsigned W        = 3,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 2,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_n_seq_checker_if.slave   bus
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    state_t               state, state_n;
    logic [MATCH_W-1:0]   match_cnt, match_n;
    logic [MISS_W-1:0]    miss_cnt, miss_n;
    logic [W-1:0]         expected_q, expected_n;
    logic                 err_pulse_q;
    logic                 locked_q;

    logic                 legal_c;
    logic                 hit_c;
    logic                 err_c;
    logic                 clr_c;
    logic [W-1:0]         nxt_in_c;
    logic [W-1:0]         nxt_exp_c;
    logic [MATCH_W-1:0]   match_inc_c;
    logic [MISS_W-1:0]    miss_inc_c;

    // Sample classification and successor values.
    assign legal_c     = 32'(bus.in_q) < N;
    assign hit_c       = legal_c && (bus.in_q == expected_q);
    assign nxt_in_c    = W'(mod_nxt(32'(bus.in_q), N));
    assign nxt_exp_c   = W'(mod_nxt(32'(expected_q), N));
    assign match_inc_c = match_cnt + MATCH_W'(1);
    assign miss_inc_c  = miss_cnt + MISS_W'(1);

`ifdef SEQ_CHK_CLR_EN
    assign clr_c = bus.err_clr;
`else
    assign clr_c = 1'b0;
`endif

    // Next-state and next-output logic; nothing moves without in_valid.
    always_comb begin
        state_n    = state;
        match_n    = match_cnt;
        miss_n     = miss_cnt;
        expected_n = expected_q;
        err_c      = 1'b0;

        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (legal_c) begin
                        expected_n = nxt_in_c;
                        match_n    = MATCH_W'(1);
                        miss_n     = '0;
                        state_n    = (LOCK_CNT == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (hit_c) begin
                        match_n    = match_inc_c;
                        expected_n = nxt_exp_c;
                        if (32'(match_inc_c) >= LOCK_CNT) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else if (legal_c) begin
                        // Re-seed from the observed value and restart the run.
                        expected_n = nxt_in_c;
                        match_n    = MATCH_W'(1);
                    end else begin
                        state_n = HUNT;
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: expected advances whether or not the sample hit.
                    expected_n = nxt_exp_c;
                    if (!hit_c) begin
                        err_c  = 1'b1;
                        miss_n = MISS_W'(1);
                        if (LOSS_CNT == 1) begin
                            state_n = HUNT;
                            match_n = '0;
                        end else begin
                            state_n = LOSS;
                        end
                    end
                end
                LOSS: begin
                    expected_n = nxt_exp_c;
                    if (hit_c) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end else begin
                        err_c  = 1'b1;
                        miss_n = miss_inc_c;
                        if (32'(miss_inc_c) >= LOSS_CNT) begin
                            state_n = HUNT;
                            match_n = '0;
                            miss_n  = '0;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    match_n = '0;
                    miss_n  = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            expected_q  <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state       <= state_n;
            match_cnt   <= match_n;
            miss_cnt    <= miss_n;
            expected_q  <= expected_n;
            err_pulse_q <= err_c;
            locked_q    <= (state_n == LOCKED) || (state_n == LOSS);
        end
    end

    // Error counter shares the err_pulse edge, so both update together.
    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_c),
        .clr   (clr_c),
        .count (bus.err_count)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.expected  = expected_q;

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Scoreboard bench for mod_n_seq_checker (N=5, LOCK_CNT=3, LOSS_CNT=2).
// Two instances share the stimulus: ERR_W=8 and ERR_W=2 (saturation).
module tb_mod_n_seq_checker;
    import mod_fsm_pkg::*;

    localparam int unsigned N        = 5;
    localparam int unsigned W        = 3;
    localparam int unsigned LOCK_CNT = 3;
    localparam int unsigned LOSS_CNT = 2;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned ERR_WS   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_n_seq_checker_if #(.W(W), .ERR_W(ERR_W))  bus ();
    mod_n_seq_checker_if #(.W(W), .ERR_W(ERR_WS)) bus_s ();

    mod_n_seq_checker #(
        .N(N), .W(W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mod_n_seq_checker #(
        .N(N), .W(W), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_WS)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

`ifdef SEQ_CHK_CLR_EN
    logic clr_drv = 1'b0;
    assign bus.err_clr   = clr_drv;
    assign bus_s.err_clr = clr_drv;
`endif

    typedef struct {
        int unsigned vec;
        logic        lk;
        logic        pl;
        logic [7:0]  cnt;
        logic [2:0]  ex;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_id = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_entry(input exp_t e);
        logic [1:0] cnt_s;
        cnt_s = (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0];
        checks++;
        if ({bus.locked, bus.err_pulse, bus.err_count, bus.expected} !== {e.lk, e.pl, e.cnt, e.ex}) begin
            errors++;
            $display("FAIL vec%0d: got locked=%0b err_pulse=%0b err_count=%0d expected=%0d, want locked=%0b err_pulse=%0b err_count=%0d expected=%0d",
                     e.vec, bus.locked, bus.err_pulse, bus.err_count, bus.expected,
                     e.lk, e.pl, e.cnt, e.ex);
        end
        checks++;
        if ({bus_s.locked, bus_s.err_pulse, bus_s.err_count, bus_s.expected} !== {e.lk, e.pl, cnt_s, e.ex}) begin
            errors++;
            $display("FAIL vec%0d_sat: got locked=%0b err_pulse=%0b err_count=%0d expected=%0d, want locked=%0b err_pulse=%0b err_count=%0d expected=%0d",
                     e.vec, bus_s.locked, bus_s.err_pulse, bus_s.err_count, bus_s.expected,
                     e.lk, e.pl, cnt_s, e.ex);
        end
    endtask

    // Drive one cycle of stimulus at the negedge and queue its expected response.
    task automatic step(input logic v, input logic [2:0] q,
                        input logic lk, input logic pl,
                        input logic [7:0] cnt, input logic [2:0] ex);
        exp_t e;
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_q       = q;
        bus_s.in_valid = v;
        bus_s.in_q     = q;
        vec_id++;
        e.vec = vec_id; e.lk = lk; e.pl = pl; e.cnt = cnt; e.ex = ex;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries pending, want 0", sb.size());
        end
    endtask

    // Monitor: outputs registered at each posedge are compared 2 time units later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_entry(e);
            end
        end
    end

    initial begin : stim
        bus.in_valid   = 1'b0;
        bus.in_q       = '0;
        bus_s.in_valid = 1'b0;
        bus_s.in_q     = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp("rst_locked",   32'(bus.locked),    32'd0);
        cmp("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        cmp("rst_err_count", 32'(bus.err_count), 32'd0);
        cmp("rst_expected", 32'(bus.expected),  32'd0);
        rst_n = 1'b1;

        // Acquire: 2,3,4 -> LOCKED expecting 0.
        step(1, 3'd2, 0, 0, 8'd0, 3'd3);
        step(1, 3'd3, 0, 0, 8'd0, 3'd4);
        step(1, 3'd4, 1, 0, 8'd0, 3'd0);
        step(0, 3'd1, 1, 0, 8'd0, 3'd0);
        // Clean run including the 4->0 wrap.
        step(1, 3'd0, 1, 0, 8'd0, 3'd1);
        step(1, 3'd1, 1, 0, 8'd0, 3'd2);
        step(1, 3'd2, 1, 0, 8'd0, 3'd3);
        step(1, 3'd3, 1, 0, 8'd0, 3'd4);
        step(1, 3'd4, 1, 0, 8'd0, 3'd0);
        step(1, 3'd0, 1, 0, 8'd0, 3'd1);
        // Expecting 1: miss 3 (flywheel to 2), then 2 matches and relocks.
        step(1, 3'd3, 1, 1, 8'd1, 3'd2);
        step(1, 3'd2, 1, 0, 8'd1, 3'd3);
        step(1, 3'd0, 1, 1, 8'd2, 3'd4);
        step(1, 3'd4, 1, 0, 8'd2, 3'd0);
        // Two consecutive misses across a gap drop lock.
        step(1, 3'd1, 1, 1, 8'd3, 3'd1);
        step(0, 3'd5, 1, 0, 8'd3, 3'd1);
        step(1, 3'd3, 0, 1, 8'd4, 3'd2);
        // SYNC after 1,2 then illegal 7 -> HUNT, no error.
        step(1, 3'd1, 0, 0, 8'd4, 3'd2);
        step(1, 3'd2, 0, 0, 8'd4, 3'd3);
        step(1, 3'd7, 0, 0, 8'd4, 3'd3);
        step(1, 3'd7, 0, 0, 8'd4, 3'd3);
        // Reacquire via 4,0,1 with a gap inside SYNC.
        step(1, 3'd4, 0, 0, 8'd4, 3'd0);
        step(0, 3'd3, 0, 0, 8'd4, 3'd0);
        step(1, 3'd0, 0, 0, 8'd4, 3'd1);
        step(1, 3'd1, 1, 0, 8'd4, 3'd2);
        // Illegal value while locked is an error; narrow counter saturates.
        step(1, 3'd6, 1, 1, 8'd5, 3'd3);
        step(1, 3'd3, 1, 0, 8'd5, 3'd4);
`ifdef SEQ_CHK_CLR_EN
        drain();
        @(negedge clk);
        clr_drv = 1'b1;
        step(1, 3'd4, 1, 0, 8'd0, 3'd0);
        step(1, 3'd1, 1, 1, 8'd0, 3'd1);
        @(posedge clk);
        @(negedge clk);
        clr_drv = 1'b0;
        step(1, 3'd1, 1, 0, 8'd0, 3'd2);
        step(0, 3'd0, 1, 0, 8'd0, 3'd2);
`else
        step(0, 3'd0, 1, 0, 8'd5, 3'd4);
`endif
        drain();

        // Asynchronous reset while locked.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_locked",   32'(bus.locked),    32'd0);
        cmp("midrst_err_count", 32'(bus.err_count), 32'd0);
        cmp("midrst_expected", 32'(bus.expected),  32'd0);
        cmp("midrst_sat_count", 32'(bus_s.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 3'd3, 0, 0, 8'd0, 3'd4);
        step(1, 3'd4, 0, 0, 8'd0, 3'd0);
        step(0, 3'd2, 0, 0, 8'd0, 3'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
